// File: rtl/gen_bus_debounce.sv
// Per-bit debouncer with edge detection for slow, already-synchronized front-panel inputs.
// A shared prescaler paces sampling; each bit must differ for DEBOUNCE_CNT ticks before it is accepted.
module gen_bus_debounce #(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter logic        RST_VAL      = 1'b0,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned PRE_WIDTH    = 16,
    parameter int unsigned DEBOUNCE_CNT = 1000,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] sync_in,
    output logic [BUS_WIDTH-1:0] db_out,
    output logic [BUS_WIDTH-1:0] rise_pulse,
    output logic [BUS_WIDTH-1:0] fall_pulse,
    output logic                 any_change
);

    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(PRESCALE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);

    logic [PRE_WIDTH-1:0] pre_q;
    logic                 tick;

    logic [CNT_WIDTH-1:0] cnt_q [BUS_WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] db_d;
    logic [BUS_WIDTH-1:0] rise_d;
    logic [BUS_WIDTH-1:0] fall_d;

    // Free-running sample-rate prescaler; with PRESCALE=1 it stays at zero and tick is constant.
    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_WIDTH'(1);
        end
    end

    // Qualification: any sample matching the current level restarts the count for that bit.
    always_comb begin
        db_d   = db_out;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(BUS_WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_in[i] == db_out[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]   = sync_in[i];
                    rise_d[i] = sync_in[i];
                    fall_d[i] = ~sync_in[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_out     <= {BUS_WIDTH{RST_VAL}};
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < int'(BUS_WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_out     <= db_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
            for (int i = 0; i < int'(BUS_WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign any_change = |{rise_pulse, fall_pulse};

endmodule

// File: tb/tb_gen_bus_debounce.sv
// Bench for gen_bus_debounce: a fast instance (PRESCALE=1, DEBOUNCE_CNT=4) and a prescaled
// instance (PRESCALE=3, DEBOUNCE_CNT=2), checked against vector tables, hand sequences and a model.
module tb_gen_bus_debounce;

    logic       clk;
    logic       rst;
    logic [7:0] in0, in1;
    logic [7:0] db0, rise0, fall0;
    logic [7:0] db1, rise1, fall1;
    logic       any0, any1;

    int checks = 0;
    int errors = 0;

    gen_bus_debounce #(
        .BUS_WIDTH(8), .RST_VAL(1'b0), .PRESCALE(1), .PRE_WIDTH(16),
        .DEBOUNCE_CNT(4), .CNT_WIDTH(16)
    ) dut0 (
        .clk(clk), .rst(rst), .sync_in(in0), .db_out(db0),
        .rise_pulse(rise0), .fall_pulse(fall0), .any_change(any0)
    );

    gen_bus_debounce #(
        .BUS_WIDTH(8), .RST_VAL(1'b0), .PRESCALE(3), .PRE_WIDTH(16),
        .DEBOUNCE_CNT(2), .CNT_WIDTH(16)
    ) dut1 (
        .clk(clk), .rst(rst), .sync_in(in1), .db_out(db1),
        .rise_pulse(rise1), .fall_pulse(fall1), .any_change(any1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bit is accepted once the number of sample ticks seen since it
    // started differing from the debounced level reaches the debounce count.
    logic [7:0] m_db   [2];
    logic [7:0] m_rise [2];
    logic [7:0] m_fall [2];
    int         m_start [2][8];
    int         cyc;

    function automatic int ps(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int dc(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_db[d]   = 8'h00;
            m_rise[d] = 8'h00;
            m_fall[d] = 8'h00;
            for (int i = 0; i < 8; i++) m_start[d][i] = -1;
        end
        cyc = 0;
    endtask

    task automatic model_edge();
        logic [7:0] vin;
        int t;
        for (int d = 0; d < 2; d++) begin
            vin       = (d == 0) ? in0 : in1;
            m_rise[d] = 8'h00;
            m_fall[d] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (vin[i] == m_db[d][i]) begin
                    m_start[d][i] = -1;
                end else begin
                    if (m_start[d][i] < 0) m_start[d][i] = cyc;
                    t = (cyc + 1) / ps(d) - m_start[d][i] / ps(d);
                    if ((cyc % ps(d)) == ps(d) - 1 && t == dc(d)) begin
                        m_db[d][i]    = vin[i];
                        m_rise[d][i]  = vin[i];
                        m_fall[d][i]  = ~vin[i];
                        m_start[d][i] = -1;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("d0 db",   db0,   m_db[0]);
        chk("d0 rise", rise0, m_rise[0]);
        chk("d0 fall", fall0, m_fall[0]);
        chk("d0 any",  {7'b0, any0}, {7'b0, |(m_rise[0] | m_fall[0])});
        chk("d1 db",   db1,   m_db[1]);
        chk("d1 rise", rise1, m_rise[1]);
        chk("d1 fall", fall1, m_fall[1]);
        chk("d1 any",  {7'b0, any1}, {7'b0, |(m_rise[1] | m_fall[1])});
    endtask

    // Called at a falling edge: apply inputs, take one rising edge, check, return at next falling edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b);
        in0 = a;
        in1 = b;
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_model();
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] vin;
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] v, input logic [7:0] d, input logic [7:0] r,
                       input logic [7:0] f, input int n);
        vec_t e;
        e.vin = v; e.db = d; e.rise = r; e.fall = f;
        for (int k = 0; k < n; k++) tbl.push_back(e);
    endtask

    logic [7:0] cur0, cur1;

    initial begin
        // Post-reset acceptance of an all-ones bus, then fall, clean rise and glitch rejection.
        add(8'hFF, 8'h00, 8'h00, 8'h00, 3);
        add(8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
        add(8'hFF, 8'hFF, 8'h00, 8'h00, 1);
        add(8'h0F, 8'hFF, 8'h00, 8'h00, 3);
        add(8'h0F, 8'h0F, 8'h00, 8'hF0, 1);
        add(8'h0F, 8'h0F, 8'h00, 8'h00, 1);
        add(8'h00, 8'h0F, 8'h00, 8'h00, 3);
        add(8'h00, 8'h00, 8'h00, 8'h0F, 1);
        add(8'h00, 8'h00, 8'h00, 8'h00, 1);
        add(8'h01, 8'h00, 8'h00, 8'h00, 3);
        add(8'h01, 8'h01, 8'h01, 8'h00, 1);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1);
        add(8'h09, 8'h01, 8'h00, 8'h00, 3);
        add(8'h01, 8'h01, 8'h00, 8'h00, 2);
        add(8'h09, 8'h01, 8'h00, 8'h00, 2);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1);
        add(8'h09, 8'h01, 8'h00, 8'h00, 3);
        add(8'h09, 8'h09, 8'h08, 8'h00, 1);
        add(8'h09, 8'h09, 8'h00, 8'h00, 1);

        rst = 1'b0;
        in0 = 8'hFF;
        in1 = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].vin, tbl[k].vin);
            chk($sformatf("tbl[%0d] db", k),   db0,   tbl[k].db);
            chk($sformatf("tbl[%0d] rise", k), rise0, tbl[k].rise);
            chk($sformatf("tbl[%0d] fall", k), fall0, tbl[k].fall);
            chk($sformatf("tbl[%0d] any", k),  {7'b0, any0}, {7'b0, |(tbl[k].rise | tbl[k].fall)});
        end

        // Reset in the middle of qualifying bit 5 discards the partial count.
        step(8'h29, 8'h09);
        step(8'h29, 8'h09);
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst d0 db", db0, 8'h00);
        chk("midrst d0 any", {7'b0, any0}, 8'h00);
        step(8'h29, 8'h02);
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(8'h29, 8'h02);
            chk($sformatf("midrst d0 db5 e%0d", k),   {7'b0, db0[5]},   {7'b0, 1'(k >= 4)});
            chk($sformatf("midrst d0 rise5 e%0d", k), {7'b0, rise0[5]}, {7'b0, 1'(k == 4)});
            chk($sformatf("presc d1 db1 e%0d", k),    {7'b0, db1[1]},   {7'b0, 1'(k >= 6)});
            chk($sformatf("presc d1 rise1 e%0d", k),  {7'b0, rise1[1]}, {7'b0, 1'(k == 6)});
        end

        // Random bus activity with per-bit toggle rates, one reset partway through.
        cur0 = 8'h29;
        cur1 = 8'h02;
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_model();
                step(cur0, cur1);
                rst = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1 + 2 * i) == 0) cur0[i] = ~cur0[i];
                if ($urandom_range(0, 1 + 2 * i) == 0) cur1[i] = ~cur1[i];
            end
            step(cur0, cur1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_bus_debounce.md
Name: gen_bus_debounce

Overview:
- Per-bit debouncer and edge detector for slow front-panel inputs (switches, push-buttons).
- Sits directly downstream of the per-bit bus synchronizer. It consumes that block's already-synchronized bus and presents clean levels plus single-cycle rise/fall pulses to the control logic.
- A shared prescaler sets the sample rate. A per-bit counter requires an input to hold a new value for a programmable number of consecutive sample ticks before accepting it.

Parameters:
- BUS_WIDTH, 8, number of independent input bits.
- RST_VAL, 1'b0, reset value of every debounced output bit. Must match the upstream synchronizer's reset value.
- PRESCALE, 1, system clocks per sample tick. Must be ≥1; 1 means a tick every clock.
- PRE_WIDTH, 16, prescaler counter width. Requires PRESCALE ≤ 2^PRE_WIDTH.
- DEBOUNCE_CNT, 1000, consecutive differing ticks required to accept a change. Must be ≥1.
- CNT_WIDTH, 16, per-bit counter width. Requires DEBOUNCE_CNT ≤ 2^CNT_WIDTH.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion is pre-synchronized externally.
- sync_in  input  BUS_WIDTH  synchronized inputs from the upstream synchronizer.
- db_out  output  BUS_WIDTH  debounced levels, registered.
- rise_pulse  output  BUS_WIDTH  one-clock pulse when db_out[i] goes 0→1, registered.
- fall_pulse  output  BUS_WIDTH  one-clock pulse when db_out[i] goes 1→0, registered.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits (combinational from registers).

Behaviour:
- Reset (rst=0, async):
  - db_out = {BUS_WIDTH{RST_VAL}}.
  - rise_pulse = 0, fall_pulse = 0, so any_change = 0.
  - Prescaler = 0; all per-bit counters = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1), combinational. With PRESCALE=1, tick is constantly 1.
  - Free-running; never gated by the inputs.
- Per bit i, every clock:
  - sync_in[i] == db_out[i]: cnt[i] <= 0, regardless of tick. Any glitch restarts qualification.
  - sync_in[i] != db_out[i] and tick and cnt[i] == DEBOUNCE_CNT-1:
    - db_out[i] <= sync_in[i]; cnt[i] <= 0.
    - rise_pulse[i] <= sync_in[i]; fall_pulse[i] <= ~sync_in[i].
  - sync_in[i] != db_out[i] and tick otherwise: cnt[i] <= cnt[i]+1.
  - sync_in[i] != db_out[i] and no tick: cnt[i] holds.
  - All cases except the accept case: rise_pulse[i] <= 0, fall_pulse[i] <= 0.
- Latency (PRESCALE=1): the input must differ on DEBOUNCE_CNT consecutive sampling edges.
  - db_out and the pulse update on the DEBOUNCE_CNT-th such edge.
  - The pulse is high for exactly the one cycle following that edge.
- DEBOUNCE_CNT=1 with PRESCALE=1: db_out follows sync_in with 1-cycle delay; a pulse fires on every change.
- Counters never exceed DEBOUNCE_CNT-1, so there is no wrap. The prescaler wraps only at PRESCALE-1.
- Bits are fully independent. Simultaneous accepts on several bits in one cycle assert all their pulses in the same cycle, and any_change is 1.
- Reset mid-qualification discards the partial count. Outputs return to reset values immediately (async), with no pulse on the reset itself.
- If the input toggles back before acceptance, no pulse is generated and db_out is unchanged.

Test Plan (PRESCALE=1, DEBOUNCE_CNT=4, BUS_WIDTH=8, RST_VAL=0 unless noted):
- Reset: hold rst=0 with sync_in=8'hFF.
  - Required: db_out=8'h00, pulses=0, any_change=0.
  - Release rst: db_out=8'hFF after 4 edges, rise_pulse=8'hFF for 1 cycle, fall_pulse=0.
- Clean rise: sync_in[0] 0→1 and held.
  - Required: db_out[0]=1 after the 4th edge; rise_pulse[0]=1 for exactly 1 cycle; any_change=1 for the same cycle; other bits unchanged.
- Glitch reject: sync_in[3]=1 for 3 cycles, then 0.
  - Required: db_out[3] stays 0 and no pulses.
  - Then 2 cycles high, 1 low, 4 high: exactly one rise_pulse[3], 4 edges after the final rise.
- Fall and multi-bit: db_out=8'hFF, then sync_in=8'h0F held.
  - Required: db_out=8'h0F after 4 edges; fall_pulse=8'hF0 for 1 cycle; rise_pulse=0.
- Reset mid-count: sync_in[5] rises; assert rst after 2 cycles; release with sync_in[5] still 1.
  - Required: db_out[5]=0 during reset; acceptance occurs 4 edges after release, not 2.
- Prescale (PRESCALE=3, DEBOUNCE_CNT=2): sync_in[1] rises and is held.
  - Required: db_out[1] updates on the 2nd tick edge after the rise (3–6 clocks depending on phase); the pulse width is 1 clock, not 1 tick.
